// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one fulladder reused for WIDTH cycles, LSB first, with a start/busy/done handshake.
// Optional build macro SERIAL_OVF_EN adds the registered signed-overflow output ovf.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  // state | meaning
  // IDLE  | waiting for start; operands captured on accept
  // ADD   | one result bit per cycle through the shared fulladder
  // DONE  | one-cycle done pulse; sum/cout already updated
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic [CW-1:0]    count;
  logic             carry, fa_s, fa_c, last;

  fulladder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  assign last = (count == LAST);
  // new bit enters at the MSB so the LSB-first result lands in order after WIDTH shifts
  assign res_nxt = (res_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ADD;
      ADD: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        ADD: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt;
          carry  <= fa_c;
          count  <= count + CW'(1);
          if (last) begin
            sum  <= res_nxt;
            cout <= fa_c;
`ifdef SERIAL_OVF_EN
            // carry still holds the carry into the MSB during the last ADD cycle
            ovf  <= carry ^ fa_c;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances, directed vectors.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0] a1, b1, sum1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_OVF_EN
    , .ovf(ovf1)
`endif
  );

`ifndef SERIAL_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t       q8[$];
  exp_t       q1[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic [7:0] held8  = 8'h00;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitors: pop one expectation per done pulse
  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done8_unexpected: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = q8.pop_front();
        chk("sum8", sum8, e.s);
        chk("cout8", cout8, e.c);
`ifdef SERIAL_OVF_EN
        chk("ovf8", ovf8, e.o);
`endif
        chk("busy8_at_done", busy8, 0);
        held8 = e.s;
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done1_unexpected: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = q1.pop_front();
        chk("sum1", sum1, e.s);
        chk("cout1", cout1, e.c);
`ifdef SERIAL_OVF_EN
        chk("ovf1", ovf1, e.o);
`endif
      end
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [7:0] es, input logic ec, input logic eo);
    int nb;
    bit moved, seen;
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    e.s = es; e.c = ec; e.o = eo;
    q8.push_back(e);
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~ci;
    nb = 0; moved = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1;
        break;
      end
      if (busy8) begin
        nb++;
        if (sum8 !== held8) moved = 1;
      end
    end
    chk("done8_seen", seen, 1);
    chk("busy8_cycles", nb, 8);
    chk("sum8_held_during_add", moved, 0);
  endtask

  task automatic run1(input logic a, input logic b, input logic ci,
                      input logic es, input logic ec, input logic eo);
    int nb;
    bit seen;
    exp_t e;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
    e.s = {7'b0, es}; e.c = ec; e.o = eo;
    q1.push_back(e);
    @(posedge clk);
    #1 start1 = 1'b0;
    nb = 0; seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done1) begin
        seen = 1;
        break;
      end
      if (busy1) nb++;
    end
    chk("done1_seen", seen, 1);
    chk("busy1_cycles", nb, 1);
  endtask

  task automatic stream_test();
    int prev, found;
    exp_t e;
    e.s = 8'h03; e.c = 1'b0; e.o = 1'b0;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    for (int k = 0; k < 3; k++) q8.push_back(e);
    start8 = 1'b1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      repeat (3) @(negedge clk);
      a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done8) begin
          found = 1;
          break;
        end
      end
      chk("done8_seen_stream", found, 1);
      if (k > 0) chk("done8_period", cyc - prev, 10);
      prev = cyc;
      if (k == 2) start8 = 1'b0;
      @(negedge clk);
    end
    held8 = 8'h03;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_sum1", sum1, 0);
`ifdef SERIAL_OVF_EN
    chk("rst_ovf8", ovf8, 0);
`endif
    rst_n = 1'b1;

    run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    run8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    run8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    stream_test();

    // abort in ADD cycle 4: no done, outputs back to reset values
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy8_before", busy8, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_sum8", sum8, 0);
    chk("abort_cout8", cout8, 0);
    held8 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("abort_busy8_after", busy8, 0);
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run8(8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    run1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    run1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    run1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
